// File: rtl/pip_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pip_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } seq_state_t;

  // Total stall cycles for a branch whose operand comes from the ALU op in ID/EX.
  localparam int BR_STALL_LONG_DEF = 2;

  // Default performance counter width.
  localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/pip_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module pip_sat_counter
  import pip_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Count enabled cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pip_stall_sequencer.sv
// Central stall/flush scheduler for the 5-stage pipeline.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | normal issue; hazard inputs decoded every cycle
//   HOLD  | extra stall cycles of a branch waiting on an ALU result in ID/EX
//
// Outputs are decoded combinationally from state, hold_cnt and the hazard
// inputs so a stall takes effect in the same cycle the hazard is flagged.
module pip_stall_sequencer
  import pip_ctrl_pkg::*;
#(
  parameter int BR_STALL_LONG = BR_STALL_LONG_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use,
  input  logic             br_hd_ex,
  input  logic             br_hd_mem,
  input  logic             br_taken,
  input  logic             jump,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             pc_redirect,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_flush,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             seq_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // hold_cnt is 2 bits, so the long stall is limited to 4 cycles in total.
  localparam bit         USE_HOLD  = (BR_STALL_LONG > 1);
  localparam logic [1:0] HOLD_LOAD = 2'(BR_STALL_LONG - 1);

  seq_state_t state, state_nxt;
  logic [1:0] hold_cnt, hold_nxt;

  // Next-state and per-stage enable/flush decode.
  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    pc_we       = 1'b0;
    pc_redirect = 1'b0;
    if_id_we    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_we    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_we   = 1'b0;
    mem_wb_we   = 1'b0;
    if (!rst_n || mem_busy) begin
      // full freeze: nothing written, state held
    end else if (state == HOLD) begin
      id_ex_we    = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_we   = 1'b1;
      mem_wb_we   = 1'b1;
      hold_nxt    = hold_cnt - 2'd1;
      if (hold_cnt == 2'd1) state_nxt = RUN;
    end else begin
      pc_we     = 1'b1;
      if_id_we  = 1'b1;
      id_ex_we  = 1'b1;
      ex_mem_we = 1'b1;
      mem_wb_we = 1'b1;
      if (br_hd_ex) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
        if (USE_HOLD) begin
          state_nxt = HOLD;
          hold_nxt  = HOLD_LOAD;
        end
      end else if (br_hd_mem || load_use) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (br_taken || jump) begin
        // br_taken only gets here with no branch data hazard pending
        pc_redirect = 1'b1;
        if_id_flush = 1'b1;
      end
    end
  end

  // State and hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      hold_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  assign seq_busy = (state == HOLD);

  pip_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~pc_we),
    .count (stall_cnt)
  );

  pip_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (if_id_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pip_stall_sequencer.sv
// Scoreboard bench for pip_stall_sequencer: a stimulus process pushes the
// reference model's expected outputs per cycle; a monitor pops and compares.
module tb_pip_stall_sequencer;

  localparam int TB_CNT_W = 4;
  localparam int BR_LONG  = 2;
  localparam int MAXC     = (1 << TB_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_use = 1'b0, br_hd_ex = 1'b0, br_hd_mem = 1'b0;
  logic br_taken = 1'b0, jump = 1'b0, mem_busy = 1'b0;
  logic pc_we, pc_redirect, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
  logic ex_mem_we, mem_wb_we, seq_busy;
  logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;

  pip_stall_sequencer #(.BR_STALL_LONG(BR_LONG), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_use(load_use), .br_hd_ex(br_hd_ex),
    .br_hd_mem(br_hd_mem), .br_taken(br_taken), .jump(jump), .mem_busy(mem_busy),
    .pc_we(pc_we), .pc_redirect(pc_redirect), .if_id_we(if_id_we),
    .if_id_flush(if_id_flush), .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush),
    .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we), .seq_busy(seq_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit pc_we, pc_redirect, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
    bit ex_mem_we, mem_wb_we, seq_busy;
    int stall_cnt, flush_cnt;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  // reference model state: remaining extra branch-stall cycles, counter values
  int rem = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic chk(input string name, input int c, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, c, act, want);
    end
  endtask

  task automatic step(input bit rst, input bit lu, input bit bex, input bit bmem,
                      input bit bt, input bit j, input bit mb);
    exp_t e;
    bit stall_like;
    @(posedge clk);
    #1;
    rst_n = rst; load_use = lu; br_hd_ex = bex; br_hd_mem = bmem;
    br_taken = bt; jump = j; mem_busy = mb;
    cyc++;
    e = '{cyc: cyc, default: 0};
    if (!rst) begin
      rem = 0; m_stall = 0; m_flush = 0;
    end else begin
      e.seq_busy  = (rem > 0);
      e.stall_cnt = m_stall;
      e.flush_cnt = m_flush;
      stall_like  = 1'b0;
      if (mb) begin
        // frozen: everything off, remaining hold untouched
      end else if (rem > 0) begin
        stall_like = 1'b1;
        rem--;
      end else if (bex) begin
        stall_like = 1'b1;
        rem = (BR_LONG > 1) ? BR_LONG - 1 : 0;
      end else if (bmem || lu) begin
        stall_like = 1'b1;
      end else begin
        e.pc_we = 1; e.if_id_we = 1; e.id_ex_we = 1; e.ex_mem_we = 1; e.mem_wb_we = 1;
        if (bt || j) begin
          e.pc_redirect = 1;
          e.if_id_flush = 1;
        end
      end
      if (stall_like) begin
        e.id_ex_we = 1; e.id_ex_flush = 1; e.ex_mem_we = 1; e.mem_wb_we = 1;
      end
      if (!e.pc_we && m_stall < MAXC) m_stall++;
      if (e.if_id_flush && m_flush < MAXC) m_flush++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pc_we",       e.cyc, int'(pc_we),       int'(e.pc_we));
        chk("pc_redirect", e.cyc, int'(pc_redirect), int'(e.pc_redirect));
        chk("if_id_we",    e.cyc, int'(if_id_we),    int'(e.if_id_we));
        chk("if_id_flush", e.cyc, int'(if_id_flush), int'(e.if_id_flush));
        chk("id_ex_we",    e.cyc, int'(id_ex_we),    int'(e.id_ex_we));
        chk("id_ex_flush", e.cyc, int'(id_ex_flush), int'(e.id_ex_flush));
        chk("ex_mem_we",   e.cyc, int'(ex_mem_we),   int'(e.ex_mem_we));
        chk("mem_wb_we",   e.cyc, int'(mem_wb_we),   int'(e.mem_wb_we));
        chk("seq_busy",    e.cyc, int'(seq_busy),    int'(e.seq_busy));
        chk("stall_cnt",   e.cyc, int'(stall_cnt),   e.stall_cnt);
        chk("flush_cnt",   e.cyc, int'(flush_cnt),   e.flush_cnt);
      end
    end
  end

  initial begin
    // reset, then release
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // single-cycle load-use stall
    step(1, 1, 0, 0, 0, 0, 0);
    idle(2);
    // long branch stall
    step(1, 0, 1, 0, 0, 0, 0);
    idle(3);
    // memory freeze during HOLD
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    idle(3);
    // branch gated by a pending load hazard, then taken
    step(1, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    idle(2);
    // jump with a load-use stall: stall first, jump next cycle
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    // inputs during HOLD are ignored
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1, 0);
    idle(2);
    // saturate stall_cnt with sustained load_use
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 1, 0);
    // reset mid-HOLD
    step(1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 149) != 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end
    idle(2);
    repeat (4) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
